dot_acc: RTL

Dot-product accumulator that sits directly downstream of the 2-stage pipelined multiplier `multi_pipe`. It tags each operand pair the source issues into the multiplier, then re-aligns those tags with the product that emerges 2 cycles later. Products are summed with saturation into a result per `in_last`-terminated group. Finished results are handed out over a valid/ready port, and credit-based backpressure is driven to the operand source.

---
 rtl/dot_acc_pkg.sv | 18 +
 rtl/dot_acc_fifo.sv | 42 ++++
 rtl/dot_acc.sv | 124 ++++++++++++
 3 files changed

// File: rtl/dot_acc_pkg.sv
// Shared constants and the default-width result record for the dot-product accumulator.
package dot_acc_pkg;

  localparam int MUL_LAT   = 2;
  localparam int RES_DEPTH = 2;
  localparam int RES_CNT_W = $clog2(RES_DEPTH + 1);

  localparam int DEF_ACC_W = 16;
  localparam int DEF_CNT_W = 8;

  // Result record at the default widths; the top re-declares it at its own widths.
  typedef struct packed {
    logic [DEF_ACC_W-1:0] data;
    logic                 ovf;
    logic [DEF_CNT_W-1:0] cnt;
  } res_t;

endpackage

// File: rtl/dot_acc_fifo.sv
// Small synchronous FIFO of result records; push and pop may coincide at any occupancy.
module dot_acc_fifo
  import dot_acc_pkg::*;
#(
  parameter type rec_t = res_t
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push_i,
  input  logic                 pop_i,
  input  rec_t                 wdata_i,
  output rec_t                 rdata_o,
  output logic [RES_CNT_W-1:0] count_o
);

  localparam int PTR_W = $clog2(RES_DEPTH);

  rec_t                 mem_q [RES_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q;
  logic [PTR_W-1:0]     rd_ptr_q;
  logic [RES_CNT_W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RES_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_i) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + RES_CNT_W'(push_i) - RES_CNT_W'(pop_i);
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/dot_acc.sv
// Saturating dot-product accumulator aligned to a 2-stage multiplier, with a credit-managed
// result FIFO. Handshake: a transfer happens on a cycle where valid and ready are both high.
module dot_acc
  import dot_acc_pkg::*;
#(
  parameter int SIZE  = 4,
  parameter int ACC_W = 16,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  input  logic [2*SIZE-1:0] prod,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res_data,
  output logic              res_ovf,
  output logic [CNT_W-1:0]  res_cnt
);

  localparam int SUM_W = ACC_W + 1;
  localparam int CR_W  = $clog2(RES_DEPTH + MUL_LAT + 1);

  typedef struct packed {
    logic [ACC_W-1:0] data;
    logic             ovf;
    logic [CNT_W-1:0] cnt;
  } rec_t;

  logic [MUL_LAT-1:0]   tag_v_q;
  logic [MUL_LAT-1:0]   tag_l_q;
  logic [ACC_W-1:0]     acc_q;
  logic                 ovf_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 first_q;

  logic                 issue;
  logic                 beat;
  logic                 push;
  logic                 pop;
  logic [SUM_W-1:0]     sum_wide;
  logic [ACC_W-1:0]     sum_d;
  logic                 ovf_d;
  logic [CNT_W-1:0]     cnt_d;
  logic [CR_W-1:0]      lasts_in_flight;
  logic [CR_W-1:0]      credit_used;
  logic [RES_CNT_W-1:0] fifo_count;
  rec_t                 push_rec;
  rec_t                 head_rec;

  assign issue = in_valid & in_ready;
  assign beat  = tag_v_q[MUL_LAT-1];
  assign push  = beat & tag_l_q[MUL_LAT-1];
  assign pop   = res_valid & res_ready;

  // Every last in flight reserves a FIFO slot, so a push can never meet a full FIFO.
  always_comb begin
    lasts_in_flight = '0;
    for (int i = 0; i < MUL_LAT; i++)
      lasts_in_flight = lasts_in_flight + CR_W'(tag_v_q[i] & tag_l_q[i]);
    credit_used = CR_W'(fifo_count) + lasts_in_flight;
  end

  assign in_ready = (credit_used < CR_W'(RES_DEPTH));

  always_comb begin
    sum_wide = (first_q ? {SUM_W{1'b0}} : {1'b0, acc_q}) + SUM_W'(prod);
    sum_d    = sum_wide[ACC_W] ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
    ovf_d    = (~first_q & ovf_q) | sum_wide[ACC_W];
    cnt_d    = first_q ? CNT_W'(1) : ((&cnt_q) ? cnt_q : cnt_q + CNT_W'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v_q <= '0;
      tag_l_q <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      first_q <= 1'b1;
    end else begin
      tag_v_q <= {tag_v_q[MUL_LAT-2:0], issue};
      tag_l_q <= {tag_l_q[MUL_LAT-2:0], in_last};
      if (beat) begin
        if (push) begin
          acc_q   <= '0;
          ovf_q   <= 1'b0;
          cnt_q   <= '0;
          first_q <= 1'b1;
        end else begin
          acc_q   <= sum_d;
          ovf_q   <= ovf_d;
          cnt_q   <= cnt_d;
          first_q <= 1'b0;
        end
      end
    end
  end

  assign push_rec = {sum_d, ovf_d, cnt_d};

  dot_acc_fifo #(
    .rec_t (rec_t)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (push_rec),
    .rdata_o (head_rec),
    .count_o (fifo_count)
  );

  assign res_valid = (fifo_count != '0);
  assign res_data  = head_rec.data;
  assign res_ovf   = head_rec.ovf;
  assign res_cnt   = head_rec.cnt;

  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
    push |-> (fifo_count < RES_CNT_W'(RES_DEPTH)));

endmodule
